// File: rtl/shake_grader.sv
// Multi-channel vibration grader: each sensor is synchronised, debounced and timed.
// Each channel gets a none/light/heavy grade with hold-off, and the grades are combined into max/irq/alarm.
module shake_grader #(
  parameter int CH       = 4,
  parameter int CNT_W    = 32,
  parameter int DEB_CYC  = 1000,
  parameter int T_LOW    = 999_999,
  parameter int T_HIGH   = 49_999_999,
  parameter int HOLD_CYC = 25_000_000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [CH-1:0]   DO,
  input  logic            clr,
  output logic [2*CH-1:0] shake_level,
  output logic [1:0]      level_max,
  output logic [2:0]      max_ch,
  output logic            irq,
  output logic            alarm
);

  localparam int DEB_W  = $clog2(DEB_CYC + 1);
  localparam int HOLD_W = $clog2(HOLD_CYC + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  T_LOW_C  = CNT_W'(T_LOW);
  localparam logic [CNT_W-1:0]  T_HIGH_C = CNT_W'(T_HIGH);
  localparam logic [DEB_W-1:0]  DEB_LAST = DEB_W'(DEB_CYC - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  for (genvar gi = 0; gi < CH; gi++) begin : g_ch
    logic             sync1;
    logic             sync2;
    logic             filt;
    logic [DEB_W-1:0] deb_cnt;

    // f only flips after DEB_CYC consecutive synchronised samples disagree with it
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync1   <= 1'b0;
        sync2   <= 1'b0;
        filt    <= 1'b0;
        deb_cnt <= '0;
      end else begin
        sync1 <= DO[gi];
        sync2 <= sync1;
        if (sync2 != filt) begin
          if (deb_cnt == DEB_LAST) begin
            filt    <= sync2;
            deb_cnt <= '0;
          end else begin
            deb_cnt <= deb_cnt + 1'b1;
          end
        end else begin
          deb_cnt <= '0;
        end
      end
    end

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  dur;
    logic [CNT_W-1:0]  dur_next;
    logic [HOLD_W-1:0] hold;
    logic [HOLD_W-1:0] hold_next;
    logic [1:0]        grade;
    logic [1:0]        grade_next;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state <= ST_IDLE;
        dur   <= '0;
        hold  <= '0;
        grade <= 2'd0;
      end else begin
        state <= state_next;
        dur   <= dur_next;
        hold  <= hold_next;
        grade <= grade_next;
      end
    end

    always_comb begin
      state_next = state;
      dur_next   = dur;
      hold_next  = hold;
      grade_next = grade;

      // Grade tracks the registered duration and only ratchets upward
      if (dur >= T_HIGH_C) begin
        grade_next = 2'd2;
      end else if ((dur >= T_LOW_C) && (grade == 2'd0)) begin
        grade_next = 2'd1;
      end

      case (state)
        ST_IDLE: begin
          if (filt) begin
            state_next = ST_ACTIVE;
            dur_next   = CNT_W'(1);
          end
        end
        ST_ACTIVE: begin
          if (filt) begin
            if (dur != CNT_MAX) begin
              dur_next = dur + 1'b1;
            end
          end else begin
            state_next = ST_HOLD;
            hold_next  = '0;
            dur_next   = '0;
          end
        end
        ST_HOLD: begin
          if (filt) begin
            state_next = ST_ACTIVE;
            dur_next   = CNT_W'(1);
          end else if (hold == HOLD_LAST) begin
            state_next = ST_IDLE;
            hold_next  = '0;
            grade_next = 2'd0;
          end else begin
            hold_next = hold + 1'b1;
          end
        end
        default: begin
          state_next = ST_IDLE;
          dur_next   = '0;
          hold_next  = '0;
          grade_next = 2'd0;
        end
      endcase

      if (clr) begin
        state_next = ST_IDLE;
        dur_next   = '0;
        hold_next  = '0;
        grade_next = 2'd0;
      end
    end

    assign shake_level[2*gi +: 2] = grade;
  end

  logic [2*CH-1:0] level_prev;
  logic [1:0]      lmax_next;
  logic [2:0]      mch_next;
  logic            any_inc;
  logic            any_heavy;

  // Strict '>' keeps the first (lowest) channel on ties
  always_comb begin
    lmax_next = 2'd0;
    mch_next  = 3'd0;
    any_inc   = 1'b0;
    any_heavy = 1'b0;
    for (int i = 0; i < CH; i++) begin
      if (shake_level[2*i +: 2] > lmax_next) begin
        lmax_next = shake_level[2*i +: 2];
        mch_next  = 3'(i);
      end
      if (shake_level[2*i +: 2] > level_prev[2*i +: 2]) begin
        any_inc = 1'b1;
      end
      if (shake_level[2*i +: 2] == 2'd2) begin
        any_heavy = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_prev <= '0;
      level_max  <= 2'd0;
      max_ch     <= 3'd0;
      irq        <= 1'b0;
      alarm      <= 1'b0;
    end else if (clr) begin
      level_prev <= '0;
      level_max  <= 2'd0;
      max_ch     <= 3'd0;
      irq        <= 1'b0;
      alarm      <= 1'b0;
    end else begin
      level_prev <= shake_level;
      level_max  <= lmax_next;
      max_ch     <= mch_next;
      irq        <= any_inc;
      alarm      <= alarm | any_heavy;
    end
  end

endmodule

// File: tb/tb_shake_grader.sv
// Scoreboard bench for shake_grader: each scenario queues expected (cycle, signal, value)
// records as it plans stimulus, then pops and compares them as the cycles elapse.
module tb_shake_grader;
  localparam int CH = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [CH-1:0] DO;
  logic          clr;
  logic [2*CH-1:0] shake_level;
  logic [1:0]    level_max;
  logic [2:0]    max_ch;
  logic          irq;
  logic          alarm;

  always #5 clk = ~clk;

  shake_grader #(
    .CH(2), .CNT_W(8), .DEB_CYC(2), .T_LOW(4), .T_HIGH(10), .HOLD_CYC(5)
  ) dut (
    .clk(clk), .rst_n(rst_n), .DO(DO), .clr(clr),
    .shake_level(shake_level), .level_max(level_max), .max_ch(max_ch),
    .irq(irq), .alarm(alarm)
  );

  localparam int S_F0 = 0, S_G0 = 1, S_G1 = 2, S_IRQ = 3, S_ALARM = 4,
                 S_LMAX = 5, S_MCH = 6, S_DUR0 = 7;

  typedef struct { int k; int sel; int val; } exp_t;
  exp_t sb[$];
  int compared = 0;
  int mismatched = 0;

  function automatic int observe(int sel);
    case (sel)
      S_F0:    return int'(dut.g_ch[0].filt);
      S_G0:    return int'(shake_level[1:0]);
      S_G1:    return int'(shake_level[3:2]);
      S_IRQ:   return int'(irq);
      S_ALARM: return int'(alarm);
      S_LMAX:  return int'(level_max);
      S_MCH:   return int'(max_ch);
      S_DUR0:  return int'(dut.g_ch[0].dur);
      default: return -1;
    endcase
  endfunction

  function automatic string sel_name(int sel);
    case (sel)
      S_F0:    return "f0";
      S_G0:    return "grade0";
      S_G1:    return "grade1";
      S_IRQ:   return "irq";
      S_ALARM: return "alarm";
      S_LMAX:  return "level_max";
      S_MCH:   return "max_ch";
      S_DUR0:  return "dur0";
      default: return "?";
    endcase
  endfunction

  task automatic expect_at(input int k, input int sel, input int val);
    exp_t e;
    e.k = k; e.sel = sel; e.val = val;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    DO    = '0;
    clr   = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset();
    int obs;
    rst_n = 1'b1; DO = '1; clr = 1'b0;
    #1 rst_n = 1'b0;
    for (int k = 0; k < 2; k++)
      for (int s = S_F0; s <= S_DUR0; s++) expect_at(k, s, 0);
    for (int k = 0; k < 2; k++) begin
      if (k == 0) #1;
      else repeat (3) @(negedge clk);
      for (int j = 0; j < sb.size(); j++) begin
        if (sb[j].k == k) begin
          obs = observe(sb[j].sel);
          compared++;
          if (obs !== sb[j].val) begin
            mismatched++;
            $display("FAIL reset %s k=%0d got %0d expected %0d", sel_name(sb[j].sel), k, obs, sb[j].val);
          end else $display("check reset %s k=%0d = %0d", sel_name(sb[j].sel), k, obs);
          sb.delete(j); j--;
        end
      end
    end
    compared++;
    if (sb.size() != 0) begin
      mismatched++; $display("FAIL reset leftover got %0d expected 0", sb.size()); sb.delete();
    end
  endtask

  task automatic test_debounce();
    int obs;
    do_reset();
    for (int k = 0; k <= 10; k++) begin
      expect_at(k, S_F0, 0); expect_at(k, S_IRQ, 0);
    end
    expect_at(10, S_G0, 0); expect_at(10, S_ALARM, 0);
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      for (int j = 0; j < sb.size(); j++) begin
        if (sb[j].k == k) begin
          obs = observe(sb[j].sel);
          compared++;
          if (obs !== sb[j].val) begin
            mismatched++;
            $display("FAIL debounce %s k=%0d got %0d expected %0d", sel_name(sb[j].sel), k, obs, sb[j].val);
          end else $display("check debounce %s k=%0d = %0d", sel_name(sb[j].sel), k, obs);
          sb.delete(j); j--;
        end
      end
      if (k == 0) DO[0] = 1'b1;
      if (k == 1) DO[0] = 1'b0;
    end
    compared++;
    if (sb.size() != 0) begin
      mismatched++; $display("FAIL debounce leftover got %0d expected 0", sb.size()); sb.delete();
    end
  endtask

  task automatic test_grading();
    int obs;
    do_reset();
    expect_at(3, S_F0, 0);  expect_at(4, S_F0, 1);
    expect_at(4, S_DUR0, 0); expect_at(5, S_DUR0, 1);
    expect_at(8, S_G0, 0);  expect_at(9, S_G0, 1);
    expect_at(9, S_IRQ, 0); expect_at(10, S_IRQ, 1); expect_at(11, S_IRQ, 0);
    expect_at(10, S_LMAX, 1);
    expect_at(14, S_G0, 1); expect_at(15, S_G0, 2);
    expect_at(15, S_ALARM, 0); expect_at(16, S_ALARM, 1);
    expect_at(16, S_IRQ, 1); expect_at(17, S_IRQ, 0);
    expect_at(16, S_LMAX, 2); expect_at(16, S_MCH, 0);
    for (int k = 0; k <= 17; k++) begin
      @(negedge clk);
      for (int j = 0; j < sb.size(); j++) begin
        if (sb[j].k == k) begin
          obs = observe(sb[j].sel);
          compared++;
          if (obs !== sb[j].val) begin
            mismatched++;
            $display("FAIL grading %s k=%0d got %0d expected %0d", sel_name(sb[j].sel), k, obs, sb[j].val);
          end else $display("check grading %s k=%0d = %0d", sel_name(sb[j].sel), k, obs);
          sb.delete(j); j--;
        end
      end
      if (k == 0) DO[0] = 1'b1;
    end
    compared++;
    if (sb.size() != 0) begin
      mismatched++; $display("FAIL grading leftover got %0d expected 0", sb.size()); sb.delete();
    end
  endtask

  task automatic test_hold_recovery();
    int obs;
    do_reset();
    expect_at(15, S_G0, 2);
    for (int k = 17; k <= 52; k++) expect_at(k, S_IRQ, 0);
    for (int k = 20; k <= 49; k++) expect_at(k, S_G0, 2);
    expect_at(25, S_DUR0, 0); expect_at(26, S_DUR0, 0); expect_at(27, S_DUR0, 1);
    expect_at(50, S_G0, 0);
    expect_at(50, S_LMAX, 2); expect_at(51, S_LMAX, 0); expect_at(51, S_MCH, 0);
    expect_at(51, S_ALARM, 1);
    for (int k = 0; k <= 52; k++) begin
      @(negedge clk);
      for (int j = 0; j < sb.size(); j++) begin
        if (sb[j].k == k) begin
          obs = observe(sb[j].sel);
          compared++;
          if (obs !== sb[j].val) begin
            mismatched++;
            $display("FAIL hold %s k=%0d got %0d expected %0d", sel_name(sb[j].sel), k, obs, sb[j].val);
          end else $display("check hold %s k=%0d = %0d", sel_name(sb[j].sel), k, obs);
          sb.delete(j); j--;
        end
      end
      if (k == 0)  DO[0] = 1'b1;
      if (k == 20) DO[0] = 1'b0;
      if (k == 22) DO[0] = 1'b1;
      if (k == 40) DO[0] = 1'b0;
    end
    compared++;
    if (sb.size() != 0) begin
      mismatched++; $display("FAIL hold leftover got %0d expected 0", sb.size()); sb.delete();
    end
  endtask

  task automatic test_priority();
    int obs;
    do_reset();
    expect_at(9, S_G1, 1);  expect_at(12, S_G0, 1);
    expect_at(15, S_G1, 2); expect_at(18, S_G0, 2);
    expect_at(10, S_LMAX, 1); expect_at(10, S_MCH, 1);
    expect_at(13, S_LMAX, 1); expect_at(13, S_MCH, 0);
    expect_at(16, S_LMAX, 2); expect_at(16, S_MCH, 1);
    expect_at(19, S_LMAX, 2); expect_at(19, S_MCH, 0);
    expect_at(10, S_IRQ, 1); expect_at(11, S_IRQ, 0);
    expect_at(13, S_IRQ, 1); expect_at(14, S_IRQ, 0);
    expect_at(16, S_IRQ, 1); expect_at(17, S_IRQ, 0);
    expect_at(19, S_IRQ, 1); expect_at(20, S_IRQ, 0);
    for (int k = 0; k <= 20; k++) begin
      @(negedge clk);
      for (int j = 0; j < sb.size(); j++) begin
        if (sb[j].k == k) begin
          obs = observe(sb[j].sel);
          compared++;
          if (obs !== sb[j].val) begin
            mismatched++;
            $display("FAIL priority %s k=%0d got %0d expected %0d", sel_name(sb[j].sel), k, obs, sb[j].val);
          end else $display("check priority %s k=%0d = %0d", sel_name(sb[j].sel), k, obs);
          sb.delete(j); j--;
        end
      end
      if (k == 0) DO[1] = 1'b1;
      if (k == 3) DO[0] = 1'b1;
    end
    compared++;
    if (sb.size() != 0) begin
      mismatched++; $display("FAIL priority leftover got %0d expected 0", sb.size()); sb.delete();
    end
  endtask

  task automatic test_ties_saturation();
    int obs;
    do_reset();
    expect_at(9, S_G0, 1);  expect_at(9, S_G1, 1);
    expect_at(15, S_G0, 2); expect_at(15, S_G1, 2);
    expect_at(10, S_LMAX, 1); expect_at(10, S_MCH, 0);
    expect_at(16, S_LMAX, 2); expect_at(16, S_MCH, 0);
    expect_at(10, S_IRQ, 1); expect_at(11, S_IRQ, 0);
    expect_at(16, S_IRQ, 1); expect_at(17, S_IRQ, 0);
    expect_at(258, S_DUR0, 254); expect_at(259, S_DUR0, 255);
    expect_at(300, S_DUR0, 255); expect_at(300, S_G0, 2);
    expect_at(300, S_IRQ, 0); expect_at(300, S_ALARM, 1);
    for (int k = 0; k <= 300; k++) begin
      @(negedge clk);
      for (int j = 0; j < sb.size(); j++) begin
        if (sb[j].k == k) begin
          obs = observe(sb[j].sel);
          compared++;
          if (obs !== sb[j].val) begin
            mismatched++;
            $display("FAIL ties %s k=%0d got %0d expected %0d", sel_name(sb[j].sel), k, obs, sb[j].val);
          end else $display("check ties %s k=%0d = %0d", sel_name(sb[j].sel), k, obs);
          sb.delete(j); j--;
        end
      end
      if (k == 0) DO = 2'b11;
    end
    compared++;
    if (sb.size() != 0) begin
      mismatched++; $display("FAIL ties leftover got %0d expected 0", sb.size()); sb.delete();
    end
  endtask

  task automatic test_clear_reset();
    int obs;
    do_reset();
    expect_at(18, S_G0, 1); expect_at(18, S_G1, 2); expect_at(18, S_ALARM, 1);
    expect_at(18, S_IRQ, 1); expect_at(18, S_LMAX, 2); expect_at(18, S_MCH, 1);
    for (int s = S_G0; s <= S_DUR0; s++) expect_at(19, s, 0);
    expect_at(19, S_F0, 1);
    expect_at(20, S_DUR0, 1);
    expect_at(23, S_G0, 0); expect_at(24, S_G0, 1); expect_at(25, S_IRQ, 1);
    expect_at(37, S_G0, 2); expect_at(37, S_G1, 2); expect_at(37, S_ALARM, 1);
    for (int s = S_F0; s <= S_DUR0; s++) expect_at(38, s, 0);
    expect_at(41, S_F0, 0); expect_at(42, S_F0, 1);
    expect_at(46, S_G0, 0); expect_at(47, S_G0, 1);
    expect_at(48, S_IRQ, 1); expect_at(48, S_G1, 0);
    for (int k = 0; k <= 48; k++) begin
      if (k == 38) #1;
      else @(negedge clk);
      for (int j = 0; j < sb.size(); j++) begin
        if (sb[j].k == k) begin
          obs = observe(sb[j].sel);
          compared++;
          if (obs !== sb[j].val) begin
            mismatched++;
            $display("FAIL clear %s k=%0d got %0d expected %0d", sel_name(sb[j].sel), k, obs, sb[j].val);
          end else $display("check clear %s k=%0d = %0d", sel_name(sb[j].sel), k, obs);
          sb.delete(j); j--;
        end
      end
      if (k == 0)  DO[1] = 1'b1;
      if (k == 8)  DO[0] = 1'b1;
      if (k == 18) clr = 1'b1;
      if (k == 19) clr = 1'b0;
      if (k == 30) DO = 2'b00;
      if (k == 37) rst_n = 1'b0;
      if (k == 38) begin
        rst_n = 1'b1;
        DO = 2'b01;
      end
    end
    compared++;
    if (sb.size() != 0) begin
      mismatched++; $display("FAIL clear leftover got %0d expected 0", sb.size()); sb.delete();
    end
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_grading();
    test_hold_recovery();
    test_priority();
    test_ties_saturation();
    test_clear_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule
